instr_prefetch_queue: RTL and testbench



---
 rtl/instr_prefetch_queue.sv | 139 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one read per cycle and buffers words for IF/ID.
// Define PREFETCH_BYPASS_EN to let a returning word fall through to the outputs when the queue is empty.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_inc_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i
);

    // state  | meaning
    // S_IDLE | waiting for start, no fetch activity
    // S_RUN  | fetching, queue live, redirects honoured
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    issued_addr_q, issued_addr_d;
    logic           pending_q, pending_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]    instr_mem_q [DEPTH];
    logic [31:0]    instr_mem_d [DEPTH];
    logic [31:0]    tag_mem_q   [DEPTH];
    logic [31:0]    tag_mem_d   [DEPTH];

    logic [31:0]    resp_tag;
    logic [CW-1:0]  fill;
    logic           bypass_act;
    logic           bypass_take;
    logic           push;
    logic           pop;

    always_comb begin
        resp_tag   = issued_addr_q + 32'd4;
        fill       = count_q + CW'(pending_q);
        mem_req_o  = (state_q == S_RUN) && !redirect_i && (fill < CW'(DEPTH));
        mem_addr_o = fetch_pc_q;

`ifdef PREFETCH_BYPASS_EN
        bypass_act = (count_q == '0) && pending_q;
`else
        bypass_act = 1'b0;
`endif

        valid_o     = bypass_act || (count_q != '0);
        instr_o     = bypass_act ? mem_data_i : instr_mem_q[rd_ptr_q];
        pc_inc_o    = bypass_act ? resp_tag   : tag_mem_q[rd_ptr_q];
        bypass_take = bypass_act && ready_i;
        pop         = (count_q != '0) && ready_i;
        // A word consumed straight from the bus never occupies a queue slot.
        push        = pending_q && !bypass_take;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        issued_addr_d = issued_addr_q;
        pending_d     = pending_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        instr_mem_d   = instr_mem_q;
        tag_mem_d     = tag_mem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    fetch_pc_d = RESET_PC;
                end
            end
            S_RUN: begin
                if (redirect_i) begin
                    // Flush: drop queued and in-flight words, keep pointers aligned.
                    count_d    = '0;
                    pending_d  = 1'b0;
                    wr_ptr_d   = rd_ptr_q;
                    fetch_pc_d = redirect_addr_i;
                end else begin
                    if (push) begin
                        instr_mem_d[wr_ptr_q] = mem_data_i;
                        tag_mem_d[wr_ptr_q]   = resp_tag;
                        wr_ptr_d              = wr_ptr_q + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                    count_d   = count_q + CW'(push) - CW'(pop);
                    pending_d = mem_req_o;
                    if (mem_req_o) begin
                        fetch_pc_d    = fetch_pc_q + 32'd4;
                        issued_addr_d = fetch_pc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            issued_addr_q <= RESET_PC;
            pending_q     <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            instr_mem_q   <= '{default: '0};
            tag_mem_q     <= '{default: '0};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            issued_addr_q <= issued_addr_d;
            pending_q     <= pending_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_mem_q   <= instr_mem_d;
            tag_mem_q     <= tag_mem_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: table-driven start sequence plus hand-written flush/stall/reset sequences.
module tb_instr_prefetch_queue;

`ifdef PREFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i = 32'h0;
    logic [31:0] instr_o;
    logic [31:0] pc_inc_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = 32'h0;

    int          errors = 0;
    int          checks = 0;
    int          xfers  = 0;
    int          x0;
    logic        tb_run = 1'b0;
    logic [31:0] sb[$];

    typedef struct {
        logic        st;
        logic        rdy;
        logic        rd;
        logic [31:0] ra;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vt[7];

    always #5 clk = ~clk;

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_i      (mem_data_i),
        .instr_o         (instr_o),
        .pc_inc_o        (pc_inc_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i)
    );

    // Memory holds word i at byte address 4i; one-cycle read latency.
    always @(posedge clk) begin
        if (mem_req_o) mem_data_i <= mem_addr_o >> 2;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_load(input logic [31:0] base);
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back(base + 32'(4 * i));
    endtask

    // One cycle: drive inputs at the falling edge, score any handshake that the next rising edge takes.
    task automatic cyc(input logic st, input logic rdy, input logic rd, input logic [31:0] ra);
        logic [31:0] e;
        @(negedge clk);
        start = st; ready_i = rdy; redirect_i = rd; redirect_addr_i = ra;
        #1;
        if (rst && valid_o && ready_i && !(redirect_i && tb_run)) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: got transfer pc_inc=%h expected none", pc_inc_o);
            end else begin
                e = sb.pop_front();
                check32("instr", instr_o, mem_word(e));
                check32("pc_inc", pc_inc_o, e + 32'd4);
                xfers++;
            end
        end
        if (!rst) begin
            tb_run = 1'b0;
            sb.delete();
        end else if (!tb_run && st) begin
            tb_run = 1'b1;
            sb_load(32'h0);
        end else if (tb_run && rd) begin
            sb_load(ra);
        end
    endtask

    task automatic idle_outputs(input string tag);
        check32({tag, "_req"},   32'(mem_req_o), 32'd0);
        check32({tag, "_valid"}, 32'(valid_o),   32'd0);
        check32({tag, "_addr"},  mem_addr_o,     32'h0);
        check32({tag, "_instr"}, instr_o,        32'h0);
        check32({tag, "_pcinc"}, pc_inc_o,       32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt = '{
            '{1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0,       32'h0},
            '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0,       32'h0},
            '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0,       32'h0},
            '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'(BYP),    32'h4},
            '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1,       32'h8},
            '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1,       32'hC},
            '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1,       32'h10}
        };

        // Reset values
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        idle_outputs("reset");
        rst = 1'b1;

        // Start sequence, redirect in IDLE and start in RUN both ignored
        xfers = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(vt[i].st, vt[i].rdy, vt[i].rd, vt[i].ra);
            check32($sformatf("vec%0d_req", i),   32'(mem_req_o), 32'(vt[i].e_req));
            check32($sformatf("vec%0d_valid", i), 32'(valid_o),   32'(vt[i].e_valid));
            check32($sformatf("vec%0d_addr", i),  mem_addr_o,     vt[i].e_addr);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0);
            check32("valid_cont", 32'(valid_o), 32'd1);
        end
        check32("stream_xfers", 32'(xfers), 32'(13 + BYP));

        // Stall: queue fills, requests stop, then drains in order at full rate
        rst = 1'b0; cyc(0, 0, 0, 0); rst = 1'b1;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        check32("full_req", 32'(mem_req_o), 32'd0);
        check32("full_valid", 32'(valid_o), 32'd1);
        x0 = xfers;
        cyc(0, 1, 0, 0);
        check32("first_pop_req", 32'(mem_req_o), 32'd0);
        cyc(0, 1, 0, 0);
        check32("resume_req", 32'(mem_req_o), 32'd1);
        check32("resume_addr", mem_addr_o, 32'h10);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        check32("drain_xfers", 32'(xfers - x0), 32'd10);

        // Redirect with three queued and one in flight
        rst = 1'b0; cyc(0, 0, 0, 0); rst = 1'b1;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h100);
        check32("redir_req", 32'(mem_req_o), 32'd0);
        cyc(0, 0, 0, 0);
        check32("flush_valid", 32'(valid_o), 32'd0);
        check32("target_req", 32'(mem_req_o), 32'd1);
        check32("target_addr", mem_addr_o, 32'h100);
        x0 = xfers;
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        check32("redir_xfers", 32'(xfers - x0), 32'(7 + BYP));

        // Redirect near the top of the address space wraps to zero
        cyc(0, 1, 1, 32'hFFFF_FFF8);
        x0 = xfers;
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
        check32("wrap_xfers", 32'(xfers - x0), 32'(4 + BYP));

        // Mid-stream reset with a request in flight, then redirect in IDLE, then restart
        rst = 1'b0; cyc(0, 1, 0, 0); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            idle_outputs("midreset");
        end
        cyc(0, 1, 1, 32'h500);
        check32("idle_redir_req", 32'(mem_req_o), 32'd0);
        check32("idle_redir_valid", 32'(valid_o), 32'd0);
        x0 = xfers;
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        check32("restart_xfers", 32'(xfers - x0), 32'(6 + BYP));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
